// File: rtl/cl_divider.sv
// Sequential carry-less (GF(2)[x]) polynomial divider.
// Divides a dividend of up to 2*m bits by a monic degree-m divisor and
// retires one quotient bit per clock. The result appears m clocks after the
// load edge. An illegal width or a non-monic divisor gives an error result
// one clock after the load edge.
//
// state  | meaning
// IDLE   | waiting for op_enable; outputs cleared
// RUN    | one reduction step per clock, k counts down from 2m-1 to m
// DONE   | result (or error) held while op_enable stays high
module cl_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          op_enable,
    input  logic [$clog2(DATA_WIDTH):0]   in_width,
    input  logic [2*DATA_WIDTH-1:0]       in_dividend,
    input  logic [DATA_WIDTH:0]           in_divisor,
    output logic [DATA_WIDTH-1:0]         out_quotient,
    output logic [DATA_WIDTH-1:0]         out_remainder,
    output logic                          op_finish,
    output logic                          op_error
);

    localparam int WW  = $clog2(DATA_WIDTH) + 1;
    localparam int DDW = 2 * DATA_WIDTH;
    localparam int KW  = $clog2(DDW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DDW-1:0]        rem_q, rem_d;
    logic [DATA_WIDTH:0]   div_q, div_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [KW-1:0]         k_q, k_d;
    logic [WW-1:0]         m_q, m_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] quot_out_q, quot_out_d;
    logic [DATA_WIDTH-1:0] rem_out_q, rem_out_d;
    logic                  finish_q, finish_d;
    logic                  error_q, error_d;

    logic [DDW-1:0]        dvd_mask;
    logic [DATA_WIDTH:0]   dsr_mask;
    logic                  monic;
    logic                  load_bad;
    logic [KW-1:0]         step_idx;
    logic [DDW-1:0]        aligned;
    logic                  top_bit;
    logic [DDW-1:0]        rem_step;
    logic [DATA_WIDTH-1:0] quo_step;

    // Operand masking, legality check and the single reduction step.
    always_comb begin
        monic = 1'b0;
        for (int i = 0; i < DDW; i++) begin
            dvd_mask[i] = (i < 2 * int'(in_width));
        end
        for (int i = 0; i <= DATA_WIDTH; i++) begin
            dsr_mask[i] = (i <= int'(in_width));
            if (i == int'(in_width)) begin
                monic = in_divisor[i];
            end
        end
        load_bad = (in_width == '0) || (int'(in_width) > DATA_WIDTH) || !monic;

        step_idx = k_q - KW'(m_q);
        aligned  = DDW'(div_q) << step_idx;
        top_bit  = rem_q[k_q];
        rem_step = top_bit ? (rem_q ^ aligned) : rem_q;
        quo_step = quo_q | (DATA_WIDTH'(top_bit) << step_idx);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        div_d      = div_q;
        quo_d      = quo_q;
        k_d        = k_q;
        m_d        = m_q;
        err_d      = err_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        finish_d   = finish_q;
        error_d    = error_q;

        case (state_q)
            S_IDLE: begin
                quot_out_d = '0;
                rem_out_d  = '0;
                finish_d   = 1'b0;
                error_d    = 1'b0;
                if (op_enable) begin
                    m_d   = in_width;
                    err_d = load_bad;
                    rem_d = in_dividend & dvd_mask;
                    div_d = in_divisor & dsr_mask;
                    quo_d = '0;
                    if (load_bad) begin
                        k_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        k_d     = KW'(2 * int'(in_width) - 1);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!op_enable) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    k_d   = k_q - 1'b1;
                    if (k_q == KW'(m_q)) begin
                        state_d    = S_DONE;
                        quot_out_d = quo_step;
                        rem_out_d  = rem_step[DATA_WIDTH-1:0];
                        finish_d   = 1'b1;
                        error_d    = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (!op_enable) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b0;
                    quot_out_d = '0;
                    rem_out_d  = '0;
                    finish_d   = 1'b0;
                    error_d    = 1'b0;
                end else begin
                    // Error result lands here one edge after the load edge.
                    finish_d = 1'b1;
                    error_d  = err_q;
                end
            end
            default: begin
                state_d    = S_IDLE;
                quot_out_d = '0;
                rem_out_d  = '0;
                finish_d   = 1'b0;
                error_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            div_q      <= '0;
            quo_q      <= '0;
            k_q        <= '0;
            m_q        <= '0;
            err_q      <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            finish_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            quo_q      <= quo_d;
            k_q        <= k_d;
            m_q        <= m_d;
            err_q      <= err_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            finish_q   <= finish_d;
            error_q    <= error_d;
        end
    end

    assign out_quotient  = quot_out_q;
    assign out_remainder = rem_out_q;
    assign op_finish     = finish_q;
    assign op_error      = error_q;

endmodule

// File: tb/tb_cl_divider.sv
// Bench for cl_divider at DATA_WIDTH=8: directed vectors, error cases,
// abort, asynchronous reset and a randomized reconstruction sweep.
module tb_cl_divider;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          op_enable;
    logic [3:0]    in_width;
    logic [15:0]   in_dividend;
    logic [8:0]    in_divisor;
    logic [7:0]    out_quotient;
    logic [7:0]    out_remainder;
    logic          op_finish;
    logic          op_error;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    cl_divider #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .op_enable     (op_enable),
        .in_width      (in_width),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .op_finish     (op_finish),
        .op_error      (op_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] clmul(input logic [8:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ (16'(a) << i);
        end
        return acc;
    endfunction

    // Start an operation, wait for op_finish, compare against the scoreboard,
    // optionally disturb inputs while busy, then release op_enable.
    task automatic run_op(input int m, input logic [15:0] dvd, input logic [8:0] dsr,
                          input logic [7:0] eq, input logic [7:0] er, input logic ee,
                          input int elat, input bit scramble);
        exp_t e;
        int   lat;
        e.q = eq; e.r = er; e.err = ee;
        sb.push_back(e);
        @(negedge clk);
        op_enable   = 1'b1;
        in_width    = 4'(m);
        in_dividend = dvd;
        in_divisor  = dsr;
        @(posedge clk); #1;
        lat = 0;
        while (!op_finish && lat < 40) begin
            if (scramble) begin
                @(negedge clk);
                in_dividend = 16'($urandom);
                in_divisor  = 9'($urandom);
                in_width    = 4'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("finish", 32'(op_finish), 32'd1);
        chk("latency", 32'(lat), 32'(elat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("quotient", 32'(out_quotient), 32'(e.q));
            chk("remainder", 32'(out_remainder), 32'(e.r));
            chk("error", 32'(op_error), 32'(e.err));
            if (scramble) begin
                repeat (3) begin
                    @(negedge clk);
                    in_dividend = 16'($urandom);
                    in_divisor  = 9'($urandom);
                    in_width    = 4'($urandom);
                    @(posedge clk); #1;
                end
                chk("hold_q", 32'(out_quotient), 32'(e.q));
                chk("hold_r", 32'(out_remainder), 32'(e.r));
                chk("hold_fin", 32'(op_finish), 32'd1);
            end
        end
        @(negedge clk);
        op_enable = 1'b0;
        @(posedge clk); #1;
        chk("clr_fin", 32'(op_finish), 32'd0);
        chk("clr_q", 32'(out_quotient), 32'd0);
        chk("clr_r", 32'(out_remainder), 32'd0);
        chk("clr_err", 32'(op_error), 32'd0);
    endtask

    initial begin
        logic [7:0]  a, b, r, mask;
        logic [8:0]  d;
        logic [15:0] dvd;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        op_enable = 1'b0;
        in_width = '0;
        in_dividend = '0;
        in_divisor = '0;
        #1;
        chk("rst_q", 32'(out_quotient), 32'd0);
        chk("rst_r", 32'(out_remainder), 32'd0);
        chk("rst_fin", 32'(op_finish), 32'd0);
        chk("rst_err", 32'(op_error), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // AES field reduction
        run_op(8, 16'h2B79, 9'h11B, 8'h28, 8'hC1, 1'b0, 8, 1'b0);
        // m=4 directed
        run_op(4, 16'h0010, 9'h013, 8'h1, 8'h3, 1'b0, 4, 1'b0);
        run_op(4, 16'h000F, 9'h013, 8'h0, 8'hF, 1'b0, 4, 1'b0);
        run_op(4, 16'hFF10, 9'h013, 8'h1, 8'h3, 1'b0, 4, 1'b0);
        // errors
        run_op(4, 16'h0010, 9'h003, 8'h0, 8'h0, 1'b1, 1, 1'b0);
        run_op(0, 16'h1234, 9'h1FF, 8'h0, 8'h0, 1'b1, 1, 1'b0);
        run_op(9, 16'h1234, 9'h1FF, 8'h0, 8'h0, 1'b1, 1, 1'b0);

        // abort at E3 of an m=8 run
        @(negedge clk);
        op_enable = 1'b1; in_width = 4'd8; in_dividend = 16'h2B79; in_divisor = 9'h11B;
        repeat (3) @(posedge clk);
        @(negedge clk);
        op_enable = 1'b0;
        @(posedge clk); #1;
        chk("abort_fin", 32'(op_finish), 32'd0);
        chk("abort_q", 32'(out_quotient), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_idle", 32'(op_finish), 32'd0);
        run_op(8, 16'h0100, 9'h11B, 8'h01, 8'h1B, 1'b0, 8, 1'b0);

        // async reset mid-RUN
        @(negedge clk);
        op_enable = 1'b1; in_width = 4'd8; in_dividend = 16'h2B79; in_divisor = 9'h11B;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_run_fin", 32'(op_finish), 32'd0);
        op_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("arst_run_idle", 32'(op_finish), 32'd0);
        run_op(4, 16'h0010, 9'h013, 8'h1, 8'h3, 1'b0, 4, 1'b0);

        // async reset while a result is held: outputs drop without a clock
        @(negedge clk);
        op_enable = 1'b1; in_width = 4'd8; in_dividend = 16'h2B79; in_divisor = 9'h11B;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_arst_q", 32'(out_quotient), 32'h28);
        #2 rst = 1'b1;
        #1;
        chk("arst_done_q", 32'(out_quotient), 32'd0);
        chk("arst_done_r", 32'(out_remainder), 32'd0);
        chk("arst_done_fin", 32'(op_finish), 32'd0);
        op_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // randomized sweep: dividend built from divisor*b ^ r plus ignored high bits
        for (int m = 1; m <= DW; m++) begin
            for (int it = 0; it < 4; it++) begin
                mask = 8'((16'd1 << m) - 16'd1);
                a = 8'($urandom) & mask;
                b = 8'($urandom) & mask;
                r = 8'($urandom) & mask;
                d = (9'd1 << m) | 9'(a);
                dvd = clmul(d, b) ^ 16'(r);
                if (m < DW) begin
                    dvd = dvd | (16'($urandom) << (2 * m));
                    d = d | (9'($urandom) << (m + 1));
                end
                run_op(m, dvd, d, b, r, 1'b0, m, (it % 2) == 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
